// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: display mode encoding.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BINARY = 2'd0;
  localparam mode_t MODE_PWM    = 2'd1;
  localparam mode_t MODE_BREATH = 2'd2;
  localparam mode_t MODE_CHASE  = 2'd3;

endpackage

// File: rtl/led_prescaler.sv
// Programmable tick prescaler: one-cycle tick every tick_div+1 enabled clocks,
// with a synchronous clear that restarts the count.
module led_prescaler #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] tick_div,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;

  // >= rather than == so a lowered tick_div reloads at once instead of wrapping.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      if (presc_q >= tick_div) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: free-running counter, prescaled tick and per-channel PWM
// driving N LEDs in binary, PWM, breathing or chase mode.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS  = 3,
  parameter int unsigned CNT_W   = 22,
  parameter int unsigned TAP_LSB = 19,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned PWM_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  mode_t                     mode,
  input  logic [PRESC_W-1:0]        tick_div,
  input  logic [N_LEDS*PWM_W-1:0]   duty,
  output logic [N_LEDS-1:0]         leds,
  output logic                      tick
);

  typedef enum logic {DirUp = 1'b0, DirDown = 1'b1} dir_e;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PWM_W-1:0]  pwm_q, pwm_d;
  logic [PWM_W-1:0]  lvl_q, lvl_d;
  dir_e              dir_q, dir_d;
  logic [N_LEDS-1:0] rot_q, rot_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  mode_t             mode_q;
  logic              mode_chg;

  logic [N_LEDS-1:0] pwm_on, breath_on;

  assign mode_chg = (mode != mode_q);

  led_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (mode_chg),
    .tick_div (tick_div),
    .tick     (tick)
  );

  // Odd channels breathe in antiphase to even ones.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    logic [PWM_W-1:0] duty_ch;
    assign duty_ch   = duty[i*PWM_W +: PWM_W];
    assign pwm_on[i] = (pwm_q < duty_ch);
    if (i % 2 == 0) begin : g_even
      assign breath_on[i] = (pwm_q < lvl_q);
    end else begin : g_odd
      assign breath_on[i] = (pwm_q < ~lvl_q);
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    pwm_d  = pwm_q;
    lvl_d  = lvl_q;
    dir_d  = dir_q;
    rot_d  = rot_q;
    leds_d = '0;
    if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
      pwm_d = pwm_q + PWM_W'(1);
      unique case (mode_q)
        MODE_BINARY: leds_d = cnt_q[TAP_LSB +: N_LEDS];
        MODE_PWM:    leds_d = pwm_on;
        MODE_BREATH: leds_d = breath_on;
        MODE_CHASE:  leds_d = rot_q;
        default:     leds_d = '0;
      endcase
      if (tick && !mode_chg) begin
        if (mode_q == MODE_BREATH) begin
          // Endpoints turn around immediately so neither extreme is held.
          if (dir_q == DirUp) begin
            if (lvl_q == '1) begin
              dir_d = DirDown;
              lvl_d = lvl_q - PWM_W'(1);
            end else begin
              lvl_d = lvl_q + PWM_W'(1);
            end
          end else if (lvl_q == '0) begin
            dir_d = DirUp;
            lvl_d = PWM_W'(1);
          end else begin
            lvl_d = lvl_q - PWM_W'(1);
          end
        end
        if (mode_q == MODE_CHASE) begin
          rot_d = (rot_q << 1) | (rot_q >> (N_LEDS - 1));
        end
      end
    end
    if (mode_chg) begin
      lvl_d = '0;
      dir_d = DirUp;
      rot_d = N_LEDS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pwm_q  <= '0;
      lvl_q  <= '0;
      dir_q  <= DirUp;
      rot_q  <= N_LEDS'(1);
      leds_q <= '0;
      mode_q <= MODE_BINARY;
    end else begin
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
      lvl_q  <= lvl_d;
      dir_q  <= dir_d;
      rot_q  <= rot_d;
      leds_q <= leds_d;
      mode_q <= mode;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (3 LEDs, 10-bit counter, 4-bit PWM).
module tb_led_pattern_gen;

  localparam int unsigned N_LEDS  = 3;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned TAP_LSB = 7;
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned PWM_W   = 4;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic [1:0]              mode;
  logic [PRESC_W-1:0]      tick_div;
  logic [N_LEDS*PWM_W-1:0] duty;
  logic [N_LEDS-1:0]       leds;
  logic                    tick;

  int checks = 0;
  int errors = 0;

  // Reference PWM counter: zero on reset, advances on every enabled edge.
  logic [PWM_W-1:0] pc;

  led_pattern_gen #(
    .N_LEDS  (N_LEDS),
    .CNT_W   (CNT_W),
    .TAP_LSB (TAP_LSB),
    .PRESC_W (PRESC_W),
    .PWM_W   (PWM_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .tick_div (tick_div),
    .duty     (duty),
    .leds     (leds),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (en) pc <= pc + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // duty = {15, 8, 0} for ch2..ch0
  function automatic logic [2:0] pwm_exp(input logic [3:0] pw);
    return {pw < 4'd15, pw < 4'd8, 1'b0};
  endfunction

  // Breathing level after s steps from 0: 0..15, 14..1, period 30.
  function automatic int blvl(input int s);
    int t;
    if (s < 0) return 0;
    t = s % 30;
    return (t <= 15) ? t : 30 - t;
  endfunction

  function automatic logic [2:0] br_exp(input logic [3:0] pw, input int l);
    logic [3:0] lv;
    lv = 4'(l);
    return {pw < lv, pw < (4'd15 - lv), pw < lv};
  endfunction

  initial begin
    int c0, c1, c2;
    rst      = 1'b1;
    en       = 1'b0;
    mode     = 2'd0;
    tick_div = '0;
    duty     = {4'd15, 4'd8, 4'd0};
    #1;
    chk("reset_leds_async", 32'(leds), 32'd0);
    chk("reset_tick_async", 32'(tick), 32'd0);
    tk(1);
    chk("reset_leds", 32'(leds), 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Binary mode: leds = cnt[9:7] delayed one clock
    tk(128);
    chk("bin_128", 32'(leds), 32'b000);
    tk(1);
    chk("bin_129", 32'(leds), 32'b001);
    tk(767);
    chk("bin_896", 32'(leds), 32'b110);
    tk(1);
    chk("bin_897", 32'(leds), 32'b111);

    // PWM mode: duty-cycle counts over one full period
    mode = 2'd1;
    tk(2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 16; i++) begin
      tk(1);
      chk("pwm_vec", 32'(leds), 32'(pwm_exp(pc - 4'd1)));
      c0 += int'(leds[0]);
      c1 += int'(leds[1]);
      c2 += int'(leds[2]);
    end
    chk("pwm_cnt_ch0", 32'(c0), 32'd0);
    chk("pwm_cnt_ch1", 32'(c1), 32'd8);
    chk("pwm_cnt_ch2", 32'(c2), 32'd15);

    // Disable: leds off next edge, PWM phase frozen
    en = 1'b0;
    tk(1);
    chk("dis_leds", 32'(leds), 32'd0);
    chk("dis_tick", 32'(tick), 32'd0);
    tk(7);
    chk("dis_leds_hold", 32'(leds), 32'd0);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tk(1);
      chk("resume_vec", 32'(leds), 32'(pwm_exp(pc - 4'd1)));
    end

    // Prescaler: period 4, then lowered to period 2, then constant
    tick_div = 8'd3;
    for (int i = 0; i < 8; i++) begin
      tk(1);
      chk("tick_div3", 32'(tick), 32'(i % 4 == 3));
    end
    for (int i = 0; i < 3; i++) begin
      tk(1);
      chk("tick_div3_tail", 32'(tick), 32'd0);
    end
    tick_div = 8'd1;
    for (int i = 0; i < 4; i++) begin
      tk(1);
      chk("tick_div1", 32'(tick), 32'(i % 2 == 0));
    end
    tick_div = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tk(1);
      chk("tick_div0", 32'(tick), 32'd1);
    end

    // Chase mode
    mode = 2'd3;
    tk(1);
    chk("chase_chg_tick", 32'(tick), 32'd0);
    tk(1);
    chk("chase_b", 32'(leds), 32'b001);
    tk(1);
    chk("chase_c", 32'(leds), 32'b001);
    tk(1);
    chk("chase_d", 32'(leds), 32'b010);
    tk(1);
    chk("chase_e", 32'(leds), 32'b100);
    tk(1);
    chk("chase_f", 32'(leds), 32'b001);

    // Switch to breath on a tick edge
    mode = 2'd2;
    tk(1);
    chk("sw_leds", 32'(leds), 32'b010);
    chk("sw_tick", 32'(tick), 32'd0);
    for (int j = 0; j <= 81; j++) begin
      tk(1);
      chk("breath", 32'(leds), 32'(br_exp(pc - 4'd1, blvl(j - 1))));
    end

    // Async reset mid-breath (lvl=9, going down)
    #2 rst = 1'b1;
    #1;
    chk("arst_leds", 32'(leds), 32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tk(1);
    chk("post_rst_leds", 32'(leds), 32'b000);
    for (int j = 0; j <= 20; j++) begin
      tk(1);
      chk("breath_rst", 32'(leds), 32'(br_exp(pc - 4'd1, blvl(j - 1))));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
